sync_burst: RTL and testbench

Pulse-burst generator directly downstream of the `sync` stage. It detects each rising edge of the single-bit sync output and emits a programmed burst of `BURST_LEN` pulses, each `PULSE_W` cycles wide and separated by `GAP` idle cycles. It reports busy/done status and counts sync edges that arrive while a burst is still running. The sync stage and this block run on the same clock, so no CDC logic is required.

---
 rtl/sync_burst_pkg.sv | 15 +
 rtl/sync_burst_if.sv | 24 ++
 rtl/sync_edge_det.sv | 19 +
 rtl/sync_burst.sv | 129 ++++++++++++
 tb/tb_sync_burst.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_burst_pkg.sv
// Shared types and default parameter values for the sync_burst slice.
package sync_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_GAP
   } sync_burst_state_t;

   localparam int DEF_BURST_LEN = 4;
   localparam int DEF_PULSE_W   = 1;
   localparam int DEF_GAP       = 2;
   localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/sync_burst_if.sv
// Bus between the sync stage side (master) and the burst generator (slave).
interface sync_burst_if
   import sync_burst_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) ();

   logic             sync_in;
   logic             burst_out;
   logic             busy;
   logic             burst_done;
   logic [CNT_W-1:0] overrun_cnt;

   modport master (
      output sync_in,
      input  burst_out, busy, burst_done, overrun_cnt
   );

   modport slave (
      input  sync_in,
      output burst_out, busy, burst_done, overrun_cnt
   );

endinterface

// File: rtl/sync_edge_det.sv
// Rising-edge detector on the sync output; the delay register resets high so a
// level already high at reset release never reads as an edge.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sync_in,
   output logic rise
);

   logic sync_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_d <= 1'b1;
      else      sync_d <= sync_in;
   end

   assign rise = sync_in & ~sync_d;

endmodule

// File: rtl/sync_burst.sv
// Burst generator triggered by sync edges. Define SYNC_BURST_RETRIG_EN to make
// an edge during a running burst restart it instead of being dropped.
module sync_burst
   import sync_burst_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int PULSE_W   = DEF_PULSE_W,
   parameter int GAP       = DEF_GAP,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   sync_burst_if.slave  bus
);

   localparam longint CNT_LIM = 64'd1 << CNT_W;

   if (BURST_LEN < 1 || longint'(BURST_LEN) >= CNT_LIM) begin : g_bad_len
      $fatal(1, "sync_burst: BURST_LEN out of range");
   end
   if (PULSE_W < 1 || longint'(PULSE_W) >= CNT_LIM) begin : g_bad_pw
      $fatal(1, "sync_burst: PULSE_W out of range");
   end
   if (GAP < 1 || longint'(GAP) >= CNT_LIM) begin : g_bad_gap
      $fatal(1, "sync_burst: GAP out of range");
   end

   localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(BURST_LEN - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   sync_burst_state_t state, state_nxt;
   logic [CNT_W-1:0]  wcnt, wcnt_nxt;
   logic [CNT_W-1:0]  pidx, pidx_nxt;
   logic [CNT_W-1:0]  ovr_cnt;
   logic              rise, active, retrig, done_nxt;
   logic              burst_out_r, busy_r, done_r;

   sync_edge_det u_edge (
      .clk     (clk),
      .rst     (rst),
      .sync_in (bus.sync_in),
      .rise    (rise)
   );

   assign active = (state != ST_IDLE);

`ifdef SYNC_BURST_RETRIG_EN
   assign retrig = rise & active;
`else
   assign retrig = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      pidx_nxt  = pidx;
      done_nxt  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (rise) begin
               state_nxt = ST_PULSE;
               wcnt_nxt  = '0;
               pidx_nxt  = '0;
            end
         end
         ST_PULSE: begin
            if (wcnt == PW_LAST) begin
               wcnt_nxt = '0;
               if (pidx == IDX_LAST) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = ST_GAP;
               end
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (wcnt == GAP_LAST) begin
               wcnt_nxt  = '0;
               pidx_nxt  = pidx + 1'b1;
               state_nxt = ST_PULSE;
            end else begin
               wcnt_nxt = wcnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // A restart overrides everything, including the done of the burst it aborts
      if (retrig) begin
         state_nxt = ST_PULSE;
         wcnt_nxt  = '0;
         pidx_nxt  = '0;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         wcnt        <= '0;
         pidx        <= '0;
         burst_out_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         ovr_cnt     <= '0;
      end else begin
         state       <= state_nxt;
         wcnt        <= wcnt_nxt;
         pidx        <= pidx_nxt;
         burst_out_r <= (state_nxt == ST_PULSE);
         busy_r      <= (state_nxt != ST_IDLE);
         done_r      <= done_nxt;
         if (rise && active) ovr_cnt <= sat_inc(ovr_cnt);
      end
   end

   assign bus.burst_out   = burst_out_r;
   assign bus.busy        = busy_r;
   assign bus.burst_done  = done_r;
   assign bus.overrun_cnt = ovr_cnt;

endmodule

// File: tb/tb_sync_burst.sv
// Bench for sync_burst: a timeline model of bursts plus directed scenarios,
// driving an 8-bit-counter instance and a 3-bit-counter instance in parallel.
module tb_sync_burst;

   localparam int BL     = 4;
   localparam int PW     = 1;
   localparam int GP     = 2;
   localparam int PERIOD = PW + GP;
   localparam int TOTAL  = BL * PW + (BL - 1) * GP;
`ifdef SYNC_BURST_RETRIG_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sync_in = 1'b1;
   int   cyc = 0;
   int   base = 0;
   int   errors = 0;
   int   checks = 0;

   sync_burst_if #(.CNT_W(8)) if_a ();
   sync_burst_if #(.CNT_W(3)) if_b ();
   assign if_a.sync_in = sync_in;
   assign if_b.sync_in = sync_in;

   sync_burst #(.BURST_LEN(BL), .PULSE_W(PW), .GAP(GP), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   sync_burst #(.BURST_LEN(BL), .PULSE_W(PW), .GAP(GP), .CNT_W(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   always #5 clk = ~clk;

   // Model: each instance remembers the cycle its current burst began (t0);
   // outputs follow from the offset into that burst.
   int t0   [2];
   bit act  [2];
   int ovr  [2];
   int omax [2] = '{255, 7};
   bit prev = 1'b1;
   bit e;

   function automatic bit m_busy(input int i, input int c);
      return act[i] && c >= t0[i] && c < t0[i] + TOTAL;
   endfunction

   function automatic bit m_out(input int i, input int c);
      return m_busy(i, c) && ((c - t0[i]) % PERIOD) < PW;
   endfunction

   function automatic bit m_done(input int i, input int c);
      return act[i] && c == t0[i] + TOTAL;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         prev = 1'b1;
         for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            ovr[i] = 0;
         end
      end else begin
         e    = sync_in & ~prev;
         prev = sync_in;
         if (e) begin
            for (int i = 0; i < 2; i++) begin
               if (m_busy(i, cyc)) begin
                  if (ovr[i] < omax[i]) ovr[i]++;
                  if (RETRIG) t0[i] = cyc + 1;
               end else begin
                  act[i] = 1'b1;
                  t0[i]  = cyc + 1;
               end
            end
         end
      end
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc - base, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_a_out",  32'(if_a.burst_out), 0);
         chk("rst_a_busy", 32'(if_a.busy), 0);
         chk("rst_a_done", 32'(if_a.burst_done), 0);
         chk("rst_a_ovr",  32'(if_a.overrun_cnt), 0);
         chk("rst_b_ovr",  32'(if_b.overrun_cnt), 0);
      end else begin
         chk("a_out",  32'(if_a.burst_out),   32'(m_out(0, cyc)));
         chk("a_busy", 32'(if_a.busy),        32'(m_busy(0, cyc)));
         chk("a_done", 32'(if_a.burst_done),  32'(m_done(0, cyc)));
         chk("a_ovr",  32'(if_a.overrun_cnt), 32'(ovr[0]));
         chk("b_out",  32'(if_b.burst_out),   32'(m_out(1, cyc)));
         chk("b_busy", 32'(if_b.busy),        32'(m_busy(1, cyc)));
         chk("b_done", 32'(if_b.burst_done),  32'(m_done(1, cyc)));
         chk("b_ovr",  32'(if_b.overrun_cnt), 32'(ovr[1]));
      end
   end

   task automatic goto(input int c);
      int n = 0;
      while (cyc != base + c) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 2000) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout target %0d now %0d", c, cyc - base);
            return;
         end
      end
   endtask

   task automatic edge_at(input int c);
      goto(c);
      sync_in = 1'b1;
      goto(c + 1);
      sync_in = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      base = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with sync_in held high through release at cycle 5
      #1 rst = 1'b0;
      #2;
      chk("reset_out",  32'(if_a.burst_out), 0);
      chk("reset_busy", 32'(if_a.busy), 0);
      chk("reset_done", 32'(if_a.burst_done), 0);
      chk("reset_ovr",  32'(if_a.overrun_cnt), 0);
      goto(5);
      rst = 1'b1;
      goto(8);  #3 chk("hi_rel_busy", 32'(if_a.busy), 0);
      goto(9);  sync_in = 1'b0;
      goto(12); #3 chk("hi_rel_busy2", 32'(if_a.busy), 0);

      // Basic burst
      do_reset();
      edge_at(10);
      goto(11); #3 chk("basic_p11", 32'(if_a.burst_out), 1);
                   chk("basic_b11", 32'(if_a.busy), 1);
      goto(12); #3 chk("basic_g12", 32'(if_a.burst_out), 0);
      goto(14); #3 chk("basic_p14", 32'(if_a.burst_out), 1);
      goto(17); #3 chk("basic_p17", 32'(if_a.burst_out), 1);
      goto(20); #3 chk("basic_p20", 32'(if_a.burst_out), 1);
                   chk("basic_b20", 32'(if_a.busy), 1);
                   chk("basic_d20", 32'(if_a.burst_done), 0);
      goto(21); #3 chk("basic_d21", 32'(if_a.burst_done), 1);
                   chk("basic_b21", 32'(if_a.busy), 0);
      goto(22); #3 chk("basic_d22", 32'(if_a.burst_done), 0);

      // Overrun during a gap
      do_reset();
      edge_at(10);
      edge_at(15);
      goto(16); #3 chk("ovr_p16", 32'(if_a.burst_out), RETRIG ? 1 : 0);
      goto(21); #3 chk("ovr_d21", 32'(if_a.burst_done), RETRIG ? 0 : 1);
                   chk("ovr_cnt", 32'(if_a.overrun_cnt), 1);
      goto(25); #3 chk("ovr_p25", 32'(if_a.burst_out), RETRIG ? 1 : 0);
      goto(26); #3 chk("ovr_d26", 32'(if_a.burst_done), RETRIG ? 1 : 0);

      // Back-to-back: new edge in the done cycle
      do_reset();
      edge_at(10);
      goto(21); #3 chk("b2b_d21", 32'(if_a.burst_done), 1);
      sync_in = 1'b1;
      goto(22); sync_in = 1'b0;
      #3 chk("b2b_p22", 32'(if_a.burst_out), 1);
         chk("b2b_ovr", 32'(if_a.overrun_cnt), 0);
      goto(32); #3 chk("b2b_d32", 32'(if_a.burst_done), 1);

      // Reset in the middle of a pulse
      do_reset();
      edge_at(10);
      edge_at(12);
      goto(14); #2 chk("mid_p14", 32'(if_a.burst_out), 1);
                   chk("mid_ovr", 32'(if_a.overrun_cnt), 1);
      #1 rst = 1'b0;
      #1 chk("mid_rst_out",  32'(if_a.burst_out), 0);
         chk("mid_rst_busy", 32'(if_a.busy), 0);
         chk("mid_rst_ovr",  32'(if_a.overrun_cnt), 0);
      goto(17); rst = 1'b1;
      goto(21); #3 chk("mid_nodone", 32'(if_a.burst_done), 0);

      // Edge storm: the 3-bit counter must stick at 7
      do_reset();
      for (int k = 0; k < 10; k++) edge_at(10 + 2 * k);
      goto(32); #3 chk("sat_b", 32'(if_b.overrun_cnt), 7);
                   chk("sat_a", 32'(if_a.overrun_cnt), RETRIG ? 9 : 8);
      goto(45);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
